// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals for the data-memory arbiter.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface dmem_arbiter_if;
   logic        c_req;
   logic        c_we;
   logic [1:0]  c_size;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic [31:0] c_rdata;
   logic        c_done;
   logic        c_err;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;

   logic [31:0] m_raddr;
   logic [31:0] m_waddr;
   logic        m_we;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   modport slave (
      input  c_req, c_we, c_size, c_addr, c_wdata,
      output c_rdata, c_done, c_err,
      input  d_req, d_we, d_addr, d_wdata,
      output d_rdata, d_done,
      output m_raddr, m_waddr, m_we, m_wdata,
      input  m_rdata
   );

   modport master (
      output c_req, c_we, c_size, c_addr, c_wdata,
      input  c_rdata, c_done, c_err,
      output d_req, d_we, d_addr, d_wdata,
      input  d_rdata, d_done,
      input  m_raddr, m_waddr, m_we, m_wdata,
      output m_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter onto a single-ported data memory with
// read-modify-write for sub-word CPU stores and starvation protection for debug.
module dmem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rst,
   dmem_arbiter_if.slave bus
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MERGE  = 2'd2,
      DONE   = 2'd3
   } arbState_e;

   // Size encoding: 2'b11 behaves exactly like a word access.
   function automatic logic isSubWord(input logic [1:0] size);
      return (size == 2'b00) || (size == 2'b01);
   endfunction

   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = lo[0];
         default: bad = (lo != 2'b00);
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] mergeLane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lo);
      logic [31:0] res;
      res = word;
      if (size == 2'b00) begin
         case (lo)
            2'b00:   res[7:0]   = data[7:0];
            2'b01:   res[15:8]  = data[7:0];
            2'b10:   res[23:16] = data[7:0];
            default: res[31:24] = data[7:0];
         endcase
      end else if (size == 2'b01) begin
         if (lo[1]) begin
            res[31:16] = data[15:0];
         end else begin
            res[15:0] = data[15:0];
         end
      end else begin
         res = data;
      end
      return res;
   endfunction

   arbState_e        state;
   arbState_e        nextState;
   logic [CNT_W-1:0] starveCnt;

   logic        grantCpu;
   logic        grantDbg;
   logic        cpuMisaligned;
   logic        nextOwnerDbg;

   logic        ownerDbg;
   logic        latWe;
   logic [1:0]  latSize;
   logic [31:0] latAddr;
   logic [31:0] latWdata;

   logic [31:0] cRdata;
   logic [31:0] dRdata;
   logic        cDone;
   logic        dDone;
   logic        cErr;
   logic        mWe;
   logic [31:0] mWdata;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Arbitration and next-state decode; requests only matter in IDLE.
   always_comb begin
      nextState     = state;
      grantCpu      = 1'b0;
      grantDbg      = 1'b0;
      cpuMisaligned = isMisaligned(bus.c_size, bus.c_addr[1:0]);
      nextOwnerDbg  = ownerDbg;
      case (state)
         IDLE: begin
            if (bus.c_req && !(bus.d_req && (starveCnt == STARVE_LIM))) begin
               grantCpu = 1'b1;
            end else if (bus.d_req) begin
               grantDbg = 1'b1;
            end else begin
               grantCpu = 1'b0;
            end
            nextOwnerDbg = grantDbg;
            if (grantCpu) begin
               nextState = cpuMisaligned ? DONE : ACCESS;
            end else if (grantDbg) begin
               nextState = ACCESS;
            end else begin
               nextState = IDLE;
            end
         end
         ACCESS: begin
            if (latWe && isSubWord(latSize)) begin
               nextState = MERGE;
            end else begin
               nextState = DONE;
            end
         end
         MERGE:   nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Consecutive CPU grants while debug is waiting; cleared whenever debug is served or idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starveCnt <= '0;
      end else if (state == IDLE) begin
         if (!bus.d_req || grantDbg) begin
            starveCnt <= '0;
         end else if (grantCpu && (starveCnt != STARVE_LIM)) begin
            starveCnt <= starveCnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Transaction latches, read capture, write-data/merge and registered handshakes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ownerDbg <= 1'b0;
         latWe    <= 1'b0;
         latSize  <= 2'b00;
         latAddr  <= 32'h0000_0000;
         latWdata <= 32'h0000_0000;
         cRdata   <= 32'h0000_0000;
         dRdata   <= 32'h0000_0000;
         cDone    <= 1'b0;
         dDone    <= 1'b0;
         cErr     <= 1'b0;
         mWe      <= 1'b0;
         mWdata   <= 32'h0000_0000;
      end else begin
         cDone <= (nextState == DONE) && (state != DONE) && !nextOwnerDbg;
         dDone <= (nextState == DONE) && (state != DONE) && nextOwnerDbg;
         cErr  <= grantCpu && cpuMisaligned;
         case (state)
            IDLE: begin
               if (grantCpu) begin
                  ownerDbg <= 1'b0;
                  latWe    <= bus.c_we;
                  latSize  <= bus.c_size;
                  latAddr  <= bus.c_addr;
                  latWdata <= bus.c_wdata;
                  mWdata   <= bus.c_wdata;
               end else if (grantDbg) begin
                  ownerDbg <= 1'b1;
                  latWe    <= bus.d_we;
                  latSize  <= 2'b10;
                  latAddr  <= bus.d_addr;
                  latWdata <= bus.d_wdata;
                  mWdata   <= bus.d_wdata;
               end
               mWe <= (grantCpu && bus.c_we && !isSubWord(bus.c_size) && !cpuMisaligned)
                      || (grantDbg && bus.d_we);
            end
            ACCESS: begin
               if (!latWe) begin
                  if (ownerDbg) begin
                     dRdata <= bus.m_rdata;
                  end else begin
                     cRdata <= bus.m_rdata;
                  end
               end
               // Sub-word store: the merged word is presented during MERGE.
               if (latWe && isSubWord(latSize)) begin
                  mWdata <= mergeLane(bus.m_rdata, latWdata, latSize, latAddr[1:0]);
                  mWe    <= 1'b1;
               end else begin
                  mWe <= 1'b0;
               end
            end
            MERGE:   mWe <= 1'b0;
            DONE:    mWe <= 1'b0;
            default: mWe <= 1'b0;
         endcase
      end
   end

   assign bus.c_rdata = cRdata;
   assign bus.d_rdata = dRdata;
   assign bus.c_done  = cDone;
   assign bus.d_done  = dDone;
   assign bus.c_err   = cErr;
   assign bus.m_raddr = {latAddr[31:2], 2'b00};
   assign bus.m_waddr = {latAddr[31:2], 2'b00};
   assign bus.m_we    = mWe;
   assign bus.m_wdata = mWdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: small word memory model, hand-computed
// expected latencies, memory contents, error flags and grant order.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.STARVE_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:63] = '{default: 32'h0000_0000};
   int          weCount    = 0;
   int          cDoneCount = 0;
   logic [31:0] lastWaddr  = 32'h0000_0000;

   assign bus.m_rdata = mem[bus.m_raddr[7:2]];

   // Memory model plus write / completion bookkeeping.
   always @(posedge clk) begin
      if (bus.m_we) begin
         mem[bus.m_waddr[7:2]] <= bus.m_wdata;
         weCount   = weCount + 1;
         lastWaddr = bus.m_waddr;
      end
      if (bus.c_done) begin
         cDoneCount = cDoneCount + 1;
      end
   end

   int assertCnt = 0;
   int failCnt   = 0;

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCnt++;
      if (got !== exp) begin
         failCnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One complete transaction on the chosen port; returns latency, error flag and write count.
   task automatic runOp(input bit dbg, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output int wes);
      int  w0;
      bit  seen;
      w0   = weCount;
      seen = 1'b0;
      lat  = 0;
      err  = 1'b0;
      @(negedge clk);
      if (dbg) begin
         bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
      end else begin
         bus.c_we = we; bus.c_size = size; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_req = 1'b1;
      end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (dbg ? bus.d_done : bus.c_done) begin
            err  = bus.c_err;
            seen = 1'b1;
            break;
         end
      end
      if (!seen) lat = 99;
      bus.c_req = 1'b0;
      bus.d_req = 1'b0;
      @(posedge clk);
      #1;
      wes = weCount - w0;
   endtask

   int          lat;
   logic        err;
   int          wes;
   logic [5:0]  seq;
   int          nDone;
   logic [31:0] starveAtDbg;
   int          w0;
   int          d0;

   initial begin
      bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_size = 2'b10; bus.c_addr = 32'h0; bus.c_wdata = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;

      // Reset state
      repeat (3) @(negedge clk);
      checkValue("rst_c_done",  {31'h0, bus.c_done}, 32'h0);
      checkValue("rst_d_done",  {31'h0, bus.d_done}, 32'h0);
      checkValue("rst_c_err",   {31'h0, bus.c_err},  32'h0);
      checkValue("rst_m_we",    {31'h0, bus.m_we},   32'h0);
      checkValue("rst_c_rdata", bus.c_rdata, 32'h0);
      checkValue("rst_d_rdata", bus.d_rdata, 32'h0);
      checkValue("rst_m_waddr", bus.m_waddr, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Word write then read back
      runOp(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, lat, err, wes);
      checkValue("ww_lat",   32'(lat), 32'd2);
      checkValue("ww_wes",   32'(wes), 32'd1);
      checkValue("ww_waddr", lastWaddr, 32'h10);
      checkValue("ww_mem",   mem[4], 32'hDEADBEEF);
      runOp(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, lat, err, wes);
      checkValue("rd_lat",   32'(lat), 32'd2);
      checkValue("rd_wes",   32'(wes), 32'd0);
      checkValue("rd_data",  bus.c_rdata, 32'hDEADBEEF);

      // Sub-word read-modify-write
      runOp(1'b0, 1'b1, 2'b11, 32'h20, 32'h11223344, lat, err, wes);
      checkValue("w11_mem",  mem[8], 32'h11223344);
      runOp(1'b0, 1'b1, 2'b00, 32'h22, 32'h000000AA, lat, err, wes);
      checkValue("sb_lat",   32'(lat), 32'd3);
      checkValue("sb_mem",   mem[8], 32'h11AA3344);
      checkValue("sb_wes",   32'(wes), 32'd1);
      runOp(1'b0, 1'b1, 2'b01, 32'h20, 32'h0000BBCC, lat, err, wes);
      checkValue("sh_lat",   32'(lat), 32'd3);
      checkValue("sh_mem",   mem[8], 32'h11AABBCC);
      runOp(1'b0, 1'b1, 2'b00, 32'h23, 32'hFFFFFF55, lat, err, wes);
      checkValue("sb3_mem",  mem[8], 32'h55AABBCC);
      runOp(1'b0, 1'b1, 2'b01, 32'h22, 32'hFFFF1234, lat, err, wes);
      checkValue("sh2_mem",  mem[8], 32'h1234BBCC);

      // Misaligned accesses
      runOp(1'b0, 1'b1, 2'b01, 32'h21, 32'h0000EEEE, lat, err, wes);
      checkValue("mis_h_lat", 32'(lat), 32'd1);
      checkValue("mis_h_err", {31'h0, err}, 32'h1);
      checkValue("mis_h_wes", 32'(wes), 32'd0);
      checkValue("mis_h_mem", mem[8], 32'h1234BBCC);
      runOp(1'b0, 1'b1, 2'b10, 32'h22, 32'h99999999, lat, err, wes);
      checkValue("mis_w_err", {31'h0, err}, 32'h1);
      checkValue("mis_w_wes", 32'(wes), 32'd0);
      runOp(1'b0, 1'b0, 2'b00, 32'h23, 32'h0, lat, err, wes);
      checkValue("rd_b_err",  {31'h0, err}, 32'h0);
      checkValue("rd_b_data", bus.c_rdata, 32'h1234BBCC);

      // Debug port: word-only, address forced to word alignment
      runOp(1'b1, 1'b1, 2'b00, 32'h33, 32'hCAFEF00D, lat, err, wes);
      checkValue("dw_lat",   32'(lat), 32'd2);
      checkValue("dw_waddr", lastWaddr, 32'h30);
      checkValue("dw_mem",   mem[12], 32'hCAFEF00D);
      runOp(1'b1, 1'b0, 2'b00, 32'h30, 32'h0, lat, err, wes);
      checkValue("dr_data",  bus.d_rdata, 32'hCAFEF00D);
      checkValue("dr_hold_c", bus.c_rdata, 32'h1234BBCC);

      // Starvation protection: both requests held continuously
      @(negedge clk);
      bus.c_we = 1'b0; bus.c_size = 2'b10; bus.c_addr = 32'h10;
      bus.d_we = 1'b0; bus.d_addr = 32'h30;
      bus.c_req = 1'b1; bus.d_req = 1'b1;
      seq = 6'b0;
      nDone = 0;
      starveAtDbg = 32'hFFFF_FFFF;
      for (int i = 0; i < 60 && nDone < 6; i++) begin
         @(posedge clk);
         #1;
         if (bus.c_done) begin
            seq[nDone] = 1'b0;
            nDone++;
         end else if (bus.d_done) begin
            seq[nDone] = 1'b1;
            nDone++;
            starveAtDbg = 32'(dut.starveCnt);
         end
      end
      bus.c_req = 1'b0; bus.d_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkValue("stv_count", 32'(nDone), 32'd6);
      checkValue("stv_order", {26'h0, seq}, 32'h10);
      checkValue("stv_cnt0",  starveAtDbg, 32'h0);
      checkValue("stv_c_rd",  bus.c_rdata, 32'hDEADBEEF);
      checkValue("stv_d_rd",  bus.d_rdata, 32'hCAFEF00D);

      // Reset during MERGE of a byte store
      w0 = weCount;
      d0 = cDoneCount;
      @(negedge clk);
      bus.c_we = 1'b1; bus.c_size = 2'b00; bus.c_addr = 32'h20; bus.c_wdata = 32'h00000077;
      bus.c_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkValue("mrg_m_we", {31'h0, bus.m_we}, 32'h1);
      rst = 1'b1;
      #1;
      checkValue("mrg_rst_we",   {31'h0, bus.m_we},   32'h0);
      checkValue("mrg_rst_done", {31'h0, bus.c_done}, 32'h0);
      bus.c_req = 1'b0;
      repeat (2) @(negedge clk);
      checkValue("mrg_rst_rd",    bus.c_rdata, 32'h0);
      checkValue("mrg_rst_waddr", bus.m_waddr, 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checkValue("mrg_no_write", 32'(weCount - w0), 32'd0);
      checkValue("mrg_no_done",  32'(cDoneCount - d0), 32'd0);
      checkValue("mrg_mem",      mem[8], 32'h1234BBCC);
      runOp(1'b0, 1'b0, 2'b10, 32'h20, 32'h0, lat, err, wes);
      checkValue("post_lat",  32'(lat), 32'd2);
      checkValue("post_data", bus.c_rdata, 32'h1234BBCC);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, consecutive CPU grants tolerated while debug waits.
REQ-002 Port: clk  in  1  sole clock; all state updates on posedge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: c_req  in  1  CPU access request.
REQ-005 Port: c_we  in  1  CPU write (1) / read (0).
REQ-006 Port: c_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-007 Port: c_addr  in  32  CPU byte address.
REQ-008 Port: c_wdata  in  32  CPU store data, right-justified for sub-word.
REQ-009 Port: c_rdata  out  32  aligned word read for CPU.
REQ-010 Port: c_done  out  1  one-cycle CPU completion pulse.
REQ-011 Port: c_err  out  1  misaligned-access flag, valid with c_done.
REQ-012 Port: d_req / d_we / d_addr[31:0] / d_wdata[31:0]  in  debug port, word-only.
REQ-013 Port: d_rdata  out  32; d_done  out  1  debug read data / completion pulse.
REQ-014 Port: m_raddr, m_waddr  out  32  word-aligned memory addresses ({addr[31:2],2'b00}).
REQ-015 Port: m_we  out  1; m_wdata  out  32; m_rdata  in  32 (combinational read of m_raddr).

Function
REQ-016 FSM states IDLE, ACCESS, MERGE, DONE; requests sampled only in IDLE.
REQ-017 IDLE: on grant, latch owner, we, size, addr, wdata; go ACCESS; else stay.
REQ-018 Arbitration: CPU wins when both request, unless starve_cnt == STARVE_MAX, then debug wins.
REQ-019 starve_cnt: +1 per CPU grant while d_req high; cleared on debug grant or when d_req low in IDLE; saturates at STARVE_MAX.
REQ-020 CPU misaligned (halfword addr[0]=1, word addr[1:0]!=0): IDLE -> DONE, no memory write, c_err=1 with c_done.
REQ-021 ACCESS read: m_raddr=latched addr; m_rdata captured into owner's rdata register; -> DONE.
REQ-022 ACCESS word write: m_we=1, m_wdata=latched wdata; -> DONE.
REQ-023 ACCESS sub-word write: read word captured into merge register, m_we=0; -> MERGE.
REQ-024 MERGE: m_we=1, m_wdata = captured word with byte lane addr[1:0] (byte) or half lane addr[1] (halfword) replaced by wdata low bits; -> DONE.
REQ-025 DONE: owner's done high exactly one cycle, other done low; -> IDLE.
REQ-026 Latency from req sampled in IDLE to done: read/word write 2 cycles, sub-word write 3, misaligned 1.
REQ-027 Requester must drop req in the cycle after done; req still high in next IDLE starts new transaction.
REQ-028 m_we high only in ACCESS (word write) or MERGE; 0 in all other states.
REQ-029 Request inputs changing after grant have no effect on the running transaction.
REQ-030 c_rdata/d_rdata hold last captured value until next read by same owner.

Reset
REQ-031 rst high: state IDLE, starve_cnt 0, m_we 0, c_done/d_done/c_err 0, c_rdata/d_rdata 0, latched fields 0, immediately.
REQ-032 rst asserted mid-transaction aborts it: no further m_we, no done pulse; after release FSM in IDLE.

Verification
REQ-033 CPU word write addr 0x10 data 0xDEADBEEF, then read 0x10 -> m_we one cycle, m_waddr 0x10; read done 2 cycles later, c_rdata 0xDEADBEEF.
REQ-034 Word 0x11223344 at 0x20; CPU byte store 0xAA to 0x22 -> c_done at 3 cycles, word becomes 0x11AA3344; halfword 0xBBCC to 0x20 -> 0x11AABBCC.
REQ-035 CPU halfword store to 0x21 -> c_done+c_err after 1 cycle, memory unchanged, m_we never high.
REQ-036 c_req and d_req held continuously, STARVE_MAX=4 -> grants CPU,CPU,CPU,CPU,debug,then CPU again; starve_cnt 0 after debug grant.
REQ-037 rst pulsed during MERGE of byte store -> no write, no c_done, outputs 0, next request served normally.
